ibexc_tsmap_arbiter: RTL and testbench

- Shares the single-port temporal-safety (TS) map SRAM between two requesters.
- Requester 0 is the core load-filter read port; requester 1 is the external revocation/allocator agent, which can read and write.
- Sits between the core's tsmap_cs_o/tsmap_addr_o/tsmap_rdata_i port and the TS map SRAM, with the external agent port alongside.
- Enforces core priority with bounded starvation of the external agent, SRAM bounds checking, and response routing.

---
 rtl/ibexc_tsmap_arbiter.sv | 140 ++++++++++++++
 tb/tb_ibexc_tsmap_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ibexc_tsmap_arbiter.sv
// Two-requester arbiter for the single-port temporal-safety map SRAM: core read port
// versus external revocation/allocator agent, with bounded ext starvation and bounds checking.
module ibexc_tsmap_arbiter #(
  parameter int TSMapSize   = 1024,
  parameter int AddrW       = 16,
  parameter int StarveLimit = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             core_req_i,
  input  logic [AddrW-1:0] core_addr_i,
  output logic             core_gnt_o,
  output logic             core_rvalid_o,
  output logic [31:0]      core_rdata_o,
  output logic             core_err_o,

  input  logic             ext_req_i,
  input  logic             ext_we_i,
  input  logic [AddrW-1:0] ext_addr_i,
  input  logic [31:0]      ext_wdata_i,
  input  logic [3:0]       ext_be_i,
  output logic             ext_gnt_o,
  output logic             ext_rvalid_o,
  output logic [31:0]      ext_rdata_o,
  output logic             ext_err_o,

  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  // Handshake: a request (req) is accepted in the cycle its gnt is high; an ungranted
  // request stays asserted with stable payload. Exactly one cycle after acceptance the
  // owner's rvalid pulses for one cycle with rdata/err; there is no backpressure on rvalid.

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_CORE = 2'd1,
    RSP_EXT  = 2'd2
  } rsp_owner_e;

  localparam logic [AddrW:0] MapSize   = (AddrW + 1)'(TSMapSize);
  localparam logic [3:0]     StarveMax = 4'(StarveLimit);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  rsp_owner_e rsp_owner_q, rsp_owner_d;
  logic       rsp_oor_q, rsp_oor_d;
  logic       rsp_we_q, rsp_we_d;

  logic core_in_range;
  logic ext_in_range;
  logic ext_forced;

  assign core_in_range = ({1'b0, core_addr_i} < MapSize);
  assign ext_in_range  = ({1'b0, ext_addr_i} < MapSize);
  assign ext_forced    = (starve_cnt_q >= StarveMax);

  // Core has priority unless ext has already lost StarveLimit cycles in a row.
  always_comb begin
    core_gnt_o = core_req_i & ~(ext_req_i & ext_forced);
    ext_gnt_o  = ext_req_i & ~core_gnt_o;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!ext_req_i || ext_gnt_o) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Out-of-range requests are granted but never reach the SRAM.
  always_comb begin
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (core_gnt_o && core_in_range) begin
      mem_cs_o   = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = core_addr_i;
    end else if (ext_gnt_o && ext_in_range) begin
      mem_cs_o    = 1'b1;
      mem_we_o    = ext_we_i;
      mem_be_o    = ext_we_i ? ext_be_i : 4'hF;
      mem_addr_o  = ext_addr_i;
      mem_wdata_o = ext_wdata_i;
    end
  end

  always_comb begin
    rsp_owner_d = RSP_NONE;
    rsp_oor_d   = 1'b0;
    rsp_we_d    = 1'b0;
    if (core_gnt_o) begin
      rsp_owner_d = RSP_CORE;
      rsp_oor_d   = ~core_in_range;
    end else if (ext_gnt_o) begin
      rsp_owner_d = RSP_EXT;
      rsp_oor_d   = ~ext_in_range;
      rsp_we_d    = ext_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= 4'd0;
      rsp_owner_q  <= RSP_NONE;
      rsp_oor_q    <= 1'b0;
      rsp_we_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_oor_q    <= rsp_oor_d;
      rsp_we_q     <= rsp_we_d;
    end
  end

  // Read data is taken straight from the SRAM output in the response cycle.
  always_comb begin
    core_rvalid_o = (rsp_owner_q == RSP_CORE);
    core_err_o    = core_rvalid_o & rsp_oor_q;
    core_rdata_o  = (core_rvalid_o && !rsp_oor_q) ? mem_rdata_i : 32'h0;
    ext_rvalid_o  = (rsp_owner_q == RSP_EXT);
    ext_err_o     = ext_rvalid_o & rsp_oor_q;
    ext_rdata_o   = (ext_rvalid_o && !rsp_oor_q && !rsp_we_q) ? mem_rdata_i : 32'h0;
  end

  a_one_grant : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(core_gnt_o && ext_gnt_o));
  a_starve_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
    starve_cnt_q <= StarveMax);

endmodule

// File: tb/tb_ibexc_tsmap_arbiter.sv
// Bench for ibexc_tsmap_arbiter: SRAM model, per-cycle reference model with response queue,
// and directed scenarios with literal expectations.
module tb_ibexc_tsmap_arbiter;
  localparam int TSMapSize   = 1024;
  localparam int AddrW       = 16;
  localparam int StarveLimit = 4;
  localparam int W           = 35;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             core_req_i, core_gnt_o, core_rvalid_o, core_err_o;
  logic [AddrW-1:0] core_addr_i;
  logic [31:0]      core_rdata_o;
  logic             ext_req_i, ext_we_i, ext_gnt_o, ext_rvalid_o, ext_err_o;
  logic [AddrW-1:0] ext_addr_i;
  logic [31:0]      ext_wdata_i, ext_rdata_o;
  logic [3:0]       ext_be_i;
  logic             mem_cs_o, mem_we_o;
  logic [3:0]       mem_be_o;
  logic [AddrW-1:0] mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i = 32'h0;

  int tests = 0;
  int failed = 0;

  always #5 clk_i = ~clk_i;

  ibexc_tsmap_arbiter #(
    .TSMapSize(TSMapSize), .AddrW(AddrW), .StarveLimit(StarveLimit)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_gnt_o(core_gnt_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i), .ext_be_i(ext_be_i), .ext_gnt_o(ext_gnt_o),
    .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o), .ext_err_o(ext_err_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // SRAM: byte-masked writes, registered reads; garbage on the output otherwise.
  logic [31:0] sram      [TSMapSize];
  logic [31:0] model_mem [TSMapSize];

  always @(posedge clk_i) begin
    if (mem_cs_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o[9:0]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        mem_rdata_i <= 32'hBADD_A7A0;
      end else begin
        mem_rdata_i <= sram[mem_addr_o[9:0]];
      end
    end else begin
      mem_rdata_i <= 32'hBADD_A7A0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ext wins once it has waited StarveLimit cycles; each grant yields
  // one response next cycle, entry = {to_core, to_ext, err, rdata}.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ex;
  int           ext_wait = 0;
  logic         e_core, e_ext, e_we, e_in;
  logic [15:0]  e_addr;
  logic [31:0]  e_wd, e_rd;
  logic [3:0]   e_be;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("rst_ctl", {core_gnt_o, ext_gnt_o, core_rvalid_o, ext_rvalid_o, core_err_o,
                      ext_err_o, mem_cs_o, mem_we_o, mem_be_o, mem_addr_o}, 64'h0);
      chk("rst_rdata", {core_rdata_o, ext_rdata_o}, 64'h0);
      chk("rst_wdata", mem_wdata_o, 64'h0);
      exp_q.delete();
      ext_wait = 0;
    end else begin
      e_ext  = ext_req_i && (!core_req_i || ext_wait >= StarveLimit);
      e_core = core_req_i && !e_ext;
      chk("core_gnt", core_gnt_o, e_core);
      chk("ext_gnt", ext_gnt_o, e_ext);
      e_we = 1'b0; e_be = 4'hF; e_wd = 32'h0; e_addr = 16'h0;
      if (e_core) e_addr = core_addr_i;
      else if (e_ext) begin
        e_addr = ext_addr_i; e_we = ext_we_i; e_wd = ext_wdata_i;
        e_be = ext_we_i ? ext_be_i : 4'hF;
      end
      e_in = (int'(e_addr) < TSMapSize);
      if ((e_core || e_ext) && e_in) begin
        chk("mem_ctl", {mem_cs_o, mem_we_o, mem_be_o, mem_addr_o}, {1'b1, e_we, e_be, e_addr});
        chk("mem_wdata", mem_wdata_o, e_wd);
      end else if (e_core || e_ext) begin
        chk("mem_cs_oor", mem_cs_o, 1'b0);
      end else begin
        chk("mem_idle", {mem_cs_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 64'h0);
      end
      ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("core_rsp", {core_rvalid_o, core_err_o, core_rdata_o},
          {ex[34], ex[34] & ex[32], ex[34] ? ex[31:0] : 32'h0});
      chk("ext_rsp", {ext_rvalid_o, ext_err_o, ext_rdata_o},
          {ex[33], ex[33] & ex[32], ex[33] ? ex[31:0] : 32'h0});
      ext_wait = (ext_req_i && !e_ext) ? ext_wait + 1 : 0;
      if (e_core || e_ext) begin
        e_rd = (e_in && !e_we) ? model_mem[e_addr[9:0]] : 32'h0;
        exp_q.push_back({e_core, e_ext, !e_in, e_rd});
        if (e_ext && e_in && e_we)
          for (int b = 0; b < 4; b++)
            if (ext_be_i[b]) model_mem[e_addr[9:0]][b*8 +: 8] = ext_wdata_i[b*8 +: 8];
      end
    end
  end

  task automatic drive(input logic cr, input logic [15:0] ca, input logic er, input logic ew,
                       input logic [15:0] ea, input logic [31:0] ed, input logic [3:0] eb);
    @(posedge clk_i); #1;
    core_req_i = cr; core_addr_i = ca;
    ext_req_i = er; ext_we_i = ew; ext_addr_i = ea; ext_wdata_i = ed; ext_be_i = eb;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
  endtask

  task automatic sample();
    @(negedge clk_i); #1;
  endtask

  initial begin
    for (int i = 0; i < TSMapSize; i++) begin
      sram[i] = 32'hC0DE_0000 | i;
      model_mem[i] = 32'hC0DE_0000 | i;
    end
    sram[16'h10] = 32'hA5A5_0001; model_mem[16'h10] = 32'hA5A5_0001;
    sram[16'h20] = 32'h1234_5678; model_mem[16'h20] = 32'h1234_5678;
    core_req_i = 0; core_addr_i = 0; ext_req_i = 0; ext_we_i = 0;
    ext_addr_i = 0; ext_wdata_i = 0; ext_be_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // core-only read
    drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0); sample();
    chk("t1_gnt", core_gnt_o, 1'b1);
    idle(); sample();
    chk("t1_rsp", {core_rvalid_o, core_err_o, core_rdata_o}, {1'b1, 1'b0, 32'hA5A5_0001});

    // partial ext write, then core read of the same word
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 32'hDEAD_BEEF, 4'b0011); sample();
    chk("t2_be", {ext_gnt_o, mem_be_o}, {1'b1, 4'b0011});
    drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0); sample();
    chk("t2_ext_rsp", {ext_rvalid_o, ext_rdata_o}, {1'b1, 32'h0});
    idle(); sample();
    chk("t2_merge", core_rdata_o, 32'h1234_BEEF);

    // continuous contention: ext wins every 5th cycle
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0, 16'h0100, 32'h0, 4'hF); sample();
      chk("t3_ext_gnt", ext_gnt_o, (i % 5) == 4);
    end
    idle(); sample();

    // bounds
    drive(1'b1, 16'd1024, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0); sample();
    chk("t4_oor_gnt", {core_gnt_o, mem_cs_o}, {1'b1, 1'b0});
    drive(1'b1, 16'd1023, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0); sample();
    chk("t4_oor_rsp", {core_rvalid_o, core_err_o, core_rdata_o}, {1'b1, 1'b1, 32'h0});
    chk("t4_last_cs", mem_cs_o, 1'b1);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF, 32'h1111_2222, 4'hF); sample();
    chk("t4_last_rsp", {core_rvalid_o, core_err_o, core_rdata_o}, {1'b1, 1'b0, 32'hC0DE_03FF});
    chk("t4_ext_oor_cs", {ext_gnt_o, mem_cs_o}, {1'b1, 1'b0});
    idle(); sample();
    chk("t4_ext_oor_rsp", {ext_rvalid_o, ext_err_o, ext_rdata_o}, {1'b1, 1'b1, 32'h0});

    // reset with a response pending and a partially built starve count
    for (int i = 0; i < 3; i++)
      drive(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0040, 32'h0, 4'hF);
    @(posedge clk_i); #1;
    rst_ni = 1'b0; core_req_i = 0; ext_req_i = 0;
    sample();
    chk("t5_no_rvalid_rst", core_rvalid_o, 1'b0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle(); sample();
      chk("t5_no_rvalid_after", {core_rvalid_o, ext_rvalid_o}, 2'b00);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0031, 1'b1, 1'b0, 16'h0041, 32'h0, 4'hF); sample();
      chk("t5_starve_restart", ext_gnt_o, i == 4);
    end
    idle();

    // ext drops after 3 lost cycles, then waits a fresh 4
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0050, 1'b1, 1'b1, 16'h0060, 32'h0BAD_F00D, 4'b1100); sample();
      chk("t6_lost", ext_gnt_o, 1'b0);
    end
    drive(1'b1, 16'h0051, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0); sample();
    chk("t6_drop", core_gnt_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0052, 1'b1, 1'b1, 16'h0060, 32'h0BAD_F00D, 4'b1100); sample();
      chk("t6_ext_gnt", ext_gnt_o, i == 4);
    end
    drive(1'b1, 16'h0060, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    idle(); sample();
    chk("t6_readback", core_rdata_o, 32'h0BAD_0060);
    idle(); idle(); sample();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
